// File: rtl/lsu_bus.sv
// Load/store unit with request/grant/response bus: little-endian byte-strobed stores,
// lane-extracted loads, alignment/access checks and a passthrough path for non-memory ops.
module lsu_bus #(
    parameter int                XLEN      = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [ADDR_W-1:0]   i_mem_addr,
    input  logic [XLEN-1:0]     i_mem_wdata,
    input  logic [10:0]         i_ls_info,
    input  logic [4:0]          i_rd_addr,
    input  logic                i_rd_wen,
    input  logic [XLEN-1:0]     i_rd_data,
    output logic                o_bus_req,
    input  logic                i_bus_gnt,
    output logic [ADDR_W-1:0]   o_bus_addr,
    output logic                o_bus_wen,
    output logic [XLEN/8-1:0]   o_bus_wstrb,
    output logic [XLEN-1:0]     o_bus_wdata,
    input  logic                i_bus_rvalid,
    input  logic [XLEN-1:0]     i_bus_rdata,
    output logic                o_wb_valid,
    output logic [XLEN-1:0]     o_wb_data,
    output logic [4:0]          o_wb_rd_addr,
    output logic                o_wb_rd_wen,
    output logic                o_exc,
    output logic [1:0]          o_exc_code
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // More than one bit set in the op vector.
    function automatic logic multi_hot(input logic [10:0] v);
        return (v & (v - 11'd1)) != 11'd0;
    endfunction

    logic              accept_s, is_mem_s, is_store_s, multi_s, illegal_s;
    logic              sz_h_s, sz_w_s, sz_d_s, mis_s, fault_s, exc_s;
    logic [1:0]        code_s;
    logic [OFF_W-1:0]  off_s;
    logic [NB-1:0]     wstrb_s;
    logic [XLEN-1:0]   wdata_s, lane_s, load_data_s;

    logic [ADDR_W-1:0] bus_addr_q;
    logic              bus_wen_q;
    logic [NB-1:0]     bus_wstrb_q;
    logic [XLEN-1:0]   bus_wdata_q;
    logic [10:0]       ls_info_q;
    logic [OFF_W-1:0]  off_q;
    logic [XLEN-1:0]   res_data_q;
    logic              res_exc_q;
    logic [1:0]        res_code_q;
    logic [4:0]        rd_addr_q;
    logic              rd_wen_q;
    logic              wb_valid_q, wb_rd_wen_q, wb_exc_q;
    logic [XLEN-1:0]   wb_data_q;
    logic [4:0]        wb_rd_addr_q;
    logic [1:0]        wb_code_q;

    // Decode the incoming op: size class, alignment, address range and exception code.
    always_comb begin
        is_mem_s   = |i_ls_info;
        is_store_s = |i_ls_info[3:0];
        multi_s    = multi_hot(i_ls_info);
        sz_h_s     = i_ls_info[7] | i_ls_info[6] | i_ls_info[1];
        sz_w_s     = i_ls_info[5] | i_ls_info[4] | i_ls_info[0];
        sz_d_s     = i_ls_info[8] | i_ls_info[2];
        illegal_s  = multi_s | ((XLEN == 32) & (i_ls_info[8] | i_ls_info[4] | i_ls_info[2]));
        mis_s      = (sz_h_s & i_mem_addr[0]) | (sz_w_s & (|i_mem_addr[1:0])) |
                     (sz_d_s & (|i_mem_addr[2:0]));
        fault_s    = i_mem_addr < BASE_ADDR;
        exc_s      = is_mem_s & (illegal_s | mis_s | fault_s);
        off_s      = i_mem_addr[OFF_W-1:0];
        if (illegal_s) begin
            code_s = 2'd3;
        end else if (mis_s) begin
            code_s = is_store_s ? 2'd1 : 2'd0;
        end else if (fault_s) begin
            code_s = 2'd2;
        end else begin
            code_s = 2'd0;
        end
    end

    // Store lane strobes and data replicated across every lane of the access size.
    always_comb begin
        wstrb_s = '0;
        wdata_s = '0;
        if (i_ls_info[3]) begin
            wstrb_s = NB'(4'h1) << off_s;
            wdata_s = {NB{i_mem_wdata[7:0]}};
        end else if (i_ls_info[1]) begin
            wstrb_s = NB'(4'h3) << off_s;
            wdata_s = {(XLEN/16){i_mem_wdata[15:0]}};
        end else if (i_ls_info[0]) begin
            wstrb_s = NB'(4'hF) << off_s;
            wdata_s = {(XLEN/32){i_mem_wdata[31:0]}};
        end else if (i_ls_info[2]) begin
            wstrb_s = '1;
            wdata_s = i_mem_wdata;
        end else begin
            wstrb_s = '0;
            wdata_s = '0;
        end
    end

    // Extract the addressed lane of the returned word and extend it.
    always_comb begin
        lane_s      = i_bus_rdata >> {off_q, 3'b000};
        load_data_s = i_bus_rdata;
        if (ls_info_q[10]) begin
            load_data_s = XLEN'($signed(lane_s[7:0]));
        end else if (ls_info_q[9]) begin
            load_data_s = XLEN'(lane_s[7:0]);
        end else if (ls_info_q[7]) begin
            load_data_s = XLEN'($signed(lane_s[15:0]));
        end else if (ls_info_q[6]) begin
            load_data_s = XLEN'(lane_s[15:0]);
        end else if (ls_info_q[5]) begin
            load_data_s = XLEN'($signed(lane_s[31:0]));
        end else if (ls_info_q[4]) begin
            load_data_s = XLEN'(lane_s[31:0]);
        end else begin
            load_data_s = i_bus_rdata;
        end
    end

    // Next-state logic; rvalid is only honoured in WAIT.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    accept_s = 1'b1;
                    state_d  = (!is_mem_s || exc_s) ? DONE : REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (i_bus_gnt) begin
                    state_d = bus_wen_q ? DONE : WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (i_bus_rvalid) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Op latch, result capture and the registered write-back stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr_q   <= '0;
            bus_wen_q    <= 1'b0;
            bus_wstrb_q  <= '0;
            bus_wdata_q  <= '0;
            ls_info_q    <= 11'd0;
            off_q        <= '0;
            res_data_q   <= '0;
            res_exc_q    <= 1'b0;
            res_code_q   <= 2'd0;
            rd_addr_q    <= 5'd0;
            rd_wen_q     <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_rd_addr_q <= 5'd0;
            wb_rd_wen_q  <= 1'b0;
            wb_exc_q     <= 1'b0;
            wb_code_q    <= 2'd0;
        end else begin
            if (accept_s) begin
                bus_addr_q  <= i_mem_addr & ~ADDR_W'(NB - 1);
                bus_wen_q   <= is_store_s;
                bus_wstrb_q <= wstrb_s;
                bus_wdata_q <= wdata_s;
                ls_info_q   <= i_ls_info;
                off_q       <= off_s;
                res_data_q  <= is_mem_s ? '0 : i_rd_data;
                res_exc_q   <= exc_s;
                res_code_q  <= exc_s ? code_s : 2'd0;
                rd_addr_q   <= i_rd_addr;
                rd_wen_q    <= i_rd_wen & ~exc_s & ~is_store_s;
            end
            if ((state_q == WAIT) && i_bus_rvalid) begin
                res_data_q <= load_data_s;
            end
            if (state_q == DONE) begin
                wb_data_q    <= res_data_q;
                wb_rd_addr_q <= rd_addr_q;
                wb_rd_wen_q  <= rd_wen_q;
                wb_exc_q     <= res_exc_q;
                wb_code_q    <= res_code_q;
            end
            wb_valid_q <= (state_q == DONE);
        end
    end

    assign o_ready      = (state_q == IDLE);
    assign o_bus_req    = (state_q == REQ);
    assign o_bus_addr   = bus_addr_q;
    assign o_bus_wen    = bus_wen_q;
    assign o_bus_wstrb  = bus_wstrb_q;
    assign o_bus_wdata  = bus_wdata_q;
    assign o_wb_valid   = wb_valid_q;
    assign o_wb_data    = wb_data_q;
    assign o_wb_rd_addr = wb_rd_addr_q;
    assign o_wb_rd_wen  = wb_rd_wen_q;
    assign o_exc        = wb_exc_q;
    assign o_exc_code   = wb_code_q;

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: a 64-bit instance with a scripted bus responder and a
// 32-bit instance with an immediate-grant responder.
module tb_lsu_bus;

    localparam logic [10:0] LB  = 11'h400, LBU = 11'h200, LD = 11'h100, LH  = 11'h080;
    localparam logic [10:0] LHU = 11'h040, LW  = 11'h020, LWU = 11'h010, SB = 11'h008;
    localparam logic [10:0] SD  = 11'h004, SH  = 11'h002, SW  = 11'h001, NOP = 11'h000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        i_valid = 1'b0, o_ready;
    logic [31:0] i_mem_addr = 32'd0;
    logic [63:0] i_mem_wdata = 64'd0, i_rd_data = 64'd0;
    logic [10:0] i_ls_info = 11'd0;
    logic [4:0]  i_rd_addr = 5'd5;
    logic        i_rd_wen = 1'b1;
    logic        o_bus_req, i_bus_gnt = 1'b0, o_bus_wen, i_bus_rvalid = 1'b0;
    logic [31:0] o_bus_addr;
    logic [7:0]  o_bus_wstrb;
    logic [63:0] o_bus_wdata, i_bus_rdata = 64'd0, o_wb_data;
    logic        o_wb_valid, o_wb_rd_wen, o_exc;
    logic [4:0]  o_wb_rd_addr;
    logic [1:0]  o_exc_code;

    lsu_bus #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .i_ls_info(i_ls_info),
        .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen), .i_rd_data(i_rd_data),
        .o_bus_req(o_bus_req), .i_bus_gnt(i_bus_gnt), .o_bus_addr(o_bus_addr),
        .o_bus_wen(o_bus_wen), .o_bus_wstrb(o_bus_wstrb), .o_bus_wdata(o_bus_wdata),
        .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata), .o_wb_valid(o_wb_valid),
        .o_wb_data(o_wb_data), .o_wb_rd_addr(o_wb_rd_addr), .o_wb_rd_wen(o_wb_rd_wen),
        .o_exc(o_exc), .o_exc_code(o_exc_code)
    );

    logic        v32 = 1'b0, rdy32, req32, gnt32, wen32, rv32 = 1'b0, wbv32, wbwen32, exc32;
    logic [31:0] addr32 = 32'd0, baddr32, bwd32, rdat32 = 32'd0, wbd32;
    logic [10:0] info32 = 11'd0;
    logic [3:0]  strb32;
    logic [4:0]  wbrd32;
    logic [1:0]  code32;

    lsu_bus #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .i_valid(v32), .o_ready(rdy32),
        .i_mem_addr(addr32), .i_mem_wdata(32'd0), .i_ls_info(info32),
        .i_rd_addr(5'd9), .i_rd_wen(1'b1), .i_rd_data(32'd0),
        .o_bus_req(req32), .i_bus_gnt(gnt32), .o_bus_addr(baddr32),
        .o_bus_wen(wen32), .o_bus_wstrb(strb32), .o_bus_wdata(bwd32),
        .i_bus_rvalid(rv32), .i_bus_rdata(rdat32), .o_wb_valid(wbv32),
        .o_wb_data(wbd32), .o_wb_rd_addr(wbrd32), .o_wb_rd_wen(wbwen32),
        .o_exc(exc32), .o_exc_code(code32)
    );

    // Immediate grant; read data returned the cycle after a granted load.
    assign gnt32 = req32;
    always @(posedge clk) rv32 <= req32 & ~wen32;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op to the 64-bit unit and act as the bus with the given grant/rvalid delays.
    task automatic run_op(input string tag, input logic [10:0] info, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [63:0] rdat, input int gdly,
                          input int rdly, input int exp_lat, input logic exp_req,
                          input logic exp_bwen, input logic [31:0] exp_baddr,
                          input logic [7:0] exp_strb, input logic [63:0] exp_bwd,
                          input logic [63:0] exp_data, input logic exp_rwen,
                          input logic exp_exc, input logic [1:0] exp_code);
        int lat = -1, pulses = 0, gcnt = 0, rcnt = 0;
        logic granted = 1'b0, rv_done = 1'b0, saw_req = 1'b0, unstable = 1'b0, rdy_bad = 1'b0;
        logic [31:0] f_addr = 32'd0;
        logic [7:0]  f_strb = 8'd0;
        logic [63:0] f_wd = 64'd0, c_data = 64'd0;
        logic        f_wen = 1'b0, c_rwen = 1'b0, c_exc = 1'b0;
        logic [1:0]  c_code = 2'd0;
        logic [4:0]  c_rd = 5'd0;
        check_val({tag, "_rdy_idle"}, {63'd0, o_ready}, 64'd1);
        i_valid = 1'b1; i_ls_info = info; i_mem_addr = addr; i_mem_wdata = wd; i_rd_data = wd;
        @(posedge clk); #1;
        i_valid = 1'b0; i_ls_info = NOP;
        for (int c = 1; c <= 40; c++) begin
            i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = ~rdat;
            if (c <= exp_lat && o_ready) rdy_bad = 1'b1;
            if (o_bus_req) begin
                if (!saw_req) begin
                    saw_req = 1'b1; f_addr = o_bus_addr; f_strb = o_bus_wstrb;
                    f_wd = o_bus_wdata; f_wen = o_bus_wen;
                end else if (o_bus_addr !== f_addr || o_bus_wstrb !== f_strb ||
                             o_bus_wdata !== f_wd || o_bus_wen !== f_wen) begin
                    unstable = 1'b1;
                end
                i_bus_rvalid = 1'b1;
                if (gcnt == gdly) begin
                    i_bus_gnt = 1'b1; granted = 1'b1;
                end else begin
                    gcnt++;
                end
            end else if (granted && !rv_done && !exp_bwen) begin
                if (rcnt == rdly) begin
                    i_bus_rvalid = 1'b1; i_bus_rdata = rdat; rv_done = 1'b1;
                end else begin
                    rcnt++;
                end
            end
            @(posedge clk); #1;
            if (o_wb_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = c; c_data = o_wb_data; c_rwen = o_wb_rd_wen; c_exc = o_exc;
                    c_code = o_exc_code; c_rd = o_wb_rd_addr;
                end
            end
        end
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
        check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_pulses"}, 64'(pulses), 64'd1);
        check_val({tag, "_ready_busy"}, {63'd0, rdy_bad}, 64'd0);
        check_val({tag, "_bus_req"}, {63'd0, saw_req}, {63'd0, exp_req});
        if (exp_req) begin
            check_val({tag, "_bus_addr"}, {32'd0, f_addr}, {32'd0, exp_baddr});
            check_val({tag, "_bus_wen"}, {63'd0, f_wen}, {63'd0, exp_bwen});
            check_val({tag, "_bus_stable"}, {63'd0, unstable}, 64'd0);
            if (exp_bwen) begin
                check_val({tag, "_wstrb"}, {56'd0, f_strb}, {56'd0, exp_strb});
                check_val({tag, "_wdata"}, f_wd, exp_bwd);
            end
        end
        check_val({tag, "_wb_data"}, c_data, exp_data);
        check_val({tag, "_wb_rd_wen"}, {63'd0, c_rwen}, {63'd0, exp_rwen});
        check_val({tag, "_wb_rd_addr"}, {59'd0, c_rd}, 64'd5);
        check_val({tag, "_exc"}, {63'd0, c_exc}, {63'd0, exp_exc});
        check_val({tag, "_exc_code"}, {62'd0, c_code}, {62'd0, exp_code});
        check_val({tag, "_wb_hold"}, o_wb_data, exp_data);
    endtask

    // Issue one op to the 32-bit unit (bus answers immediately).
    task automatic run32(input string tag, input logic [10:0] info, input logic [31:0] addr,
                         input logic [31:0] rdat, input int exp_lat, input logic [31:0] exp_data,
                         input logic exp_exc, input logic [1:0] exp_code);
        int lat = -1;
        logic [31:0] c_data = 32'd0;
        logic        c_exc = 1'b0;
        logic [1:0]  c_code = 2'd0;
        v32 = 1'b1; info32 = info; addr32 = addr; rdat32 = rdat;
        @(posedge clk); #1;
        v32 = 1'b0; info32 = NOP;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (wbv32 && lat < 0) begin
                lat = c; c_data = wbd32; c_exc = exc32; c_code = code32;
            end
        end
        check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_wb_data"}, {32'd0, c_data}, {32'd0, exp_data});
        check_val({tag, "_exc"}, {63'd0, c_exc}, {63'd0, exp_exc});
        check_val({tag, "_exc_code"}, {62'd0, c_code}, {62'd0, exp_code});
    endtask

    initial begin
        int pulses;
        #12;
        check_val("rst_ready", {63'd0, o_ready}, 64'd1);
        check_val("rst_bus_req", {63'd0, o_bus_req}, 64'd0);
        check_val("rst_wb_valid", {63'd0, o_wb_valid}, 64'd0);
        check_val("rst_wstrb", {56'd0, o_bus_wstrb}, 64'd0);
        check_val("rst_wb_data", o_wb_data, 64'd0);
        check_val("rst_exc", {63'd0, o_exc}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //      tag        info     addr           wdata / rd_data          rdata                   g  r  lat req bwen bus_addr      strb   bus_wdata                wb_data                  rwen exc code
        run_op("lh_neg",   LH,      32'h8000_0006, 64'd0,                   64'h8001_0000_0000_0000, 0, 0, 3, 1, 0, 32'h8000_0000, 8'h00, 64'd0,                   64'hFFFF_FFFF_FFFF_8001, 1, 0, 2'd0);
        run_op("sb_lane3", SB,      32'h8000_0003, 64'h0000_0000_0000_00A5, 64'd0,                   0, 0, 2, 1, 1, 32'h8000_0000, 8'h08, 64'hA5A5_A5A5_A5A5_A5A5, 64'd0,                   0, 0, 2'd0);
        run_op("lw_mis",   LW,      32'h8000_0002, 64'd0,                   64'd0,                   0, 0, 1, 0, 0, 32'd0,         8'h00, 64'd0,                   64'd0,                   0, 1, 2'd0);
        run_op("sd_mis",   SD,      32'h8000_0004, 64'd0,                   64'd0,                   0, 0, 1, 0, 0, 32'd0,         8'h00, 64'd0,                   64'd0,                   0, 1, 2'd1);
        run_op("lb_fault", LB,      32'h7FFF_FFF0, 64'd0,                   64'd0,                   0, 0, 1, 0, 0, 32'd0,         8'h00, 64'd0,                   64'd0,                   0, 1, 2'd2);
        run_op("lh_prio",  LH,      32'h7FFF_FFF1, 64'd0,                   64'd0,                   0, 0, 1, 0, 0, 32'd0,         8'h00, 64'd0,                   64'd0,                   0, 1, 2'd0);
        run_op("multi",    LB | SW, 32'h8000_0000, 64'd0,                   64'd0,                   0, 0, 1, 0, 0, 32'd0,         8'h00, 64'd0,                   64'd0,                   0, 1, 2'd3);
        run_op("lwu_stall",LWU,     32'h8000_0004, 64'd0,                   64'h89AB_CDEF_0123_4567, 3, 4,10, 1, 0, 32'h8000_0000, 8'h00, 64'd0,                   64'h0000_0000_89AB_CDEF, 1, 0, 2'd0);
        run_op("sh_stall", SH,      32'h8000_000A, 64'h0000_0000_1234_BEEF, 64'd0,                   2, 0, 4, 1, 1, 32'h8000_0008, 8'h0C, 64'hBEEF_BEEF_BEEF_BEEF, 64'd0,                   0, 0, 2'd0);
        run_op("sw_hi",    SW,      32'h8000_0004, 64'h0000_0000_DEAD_BEEF, 64'd0,                   0, 0, 2, 1, 1, 32'h8000_0000, 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0,                   0, 0, 2'd0);
        run_op("sd_full",  SD,      32'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'd0,                   0, 0, 2, 1, 1, 32'h8000_0008, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0,                   0, 0, 2'd0);
        run_op("ld_full",  LD,      32'h8000_0010, 64'd0,                   64'hFEDC_BA98_7654_3210, 0, 0, 3, 1, 0, 32'h8000_0010, 8'h00, 64'd0,                   64'hFEDC_BA98_7654_3210, 1, 0, 2'd0);
        run_op("lb_sext",  LB,      32'h8000_0001, 64'd0,                   64'h1122_3344_5566_FE77, 0, 1, 4, 1, 0, 32'h8000_0000, 8'h00, 64'd0,                   64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 2'd0);
        run_op("lbu_top",  LBU,     32'h8000_0007, 64'd0,                   64'h9A00_0000_0000_0000, 0, 0, 3, 1, 0, 32'h8000_0000, 8'h00, 64'd0,                   64'h0000_0000_0000_009A, 1, 0, 2'd0);
        run_op("lhu_zext", LHU,     32'h8000_0006, 64'd0,                   64'h8001_0000_0000_0000, 0, 0, 3, 1, 0, 32'h8000_0000, 8'h00, 64'd0,                   64'h0000_0000_0000_8001, 1, 0, 2'd0);
        run_op("passthru", NOP,     32'h0000_0000, 64'h0000_0000_0000_1234, 64'd0,                   0, 0, 1, 0, 0, 32'd0,         8'h00, 64'd0,                   64'h0000_0000_0000_1234, 1, 0, 2'd0);

        // Back-to-back passthrough ops: accepted every second cycle.
        i_valid = 1'b1; i_ls_info = NOP; i_rd_data = 64'h1111;
        @(posedge clk); #1;
        check_val("b2b_busy", {63'd0, o_ready}, 64'd0);
        i_rd_data = 64'h2222;
        @(posedge clk); #1;
        check_val("b2b_first_valid", {63'd0, o_wb_valid}, 64'd1);
        check_val("b2b_first_data", o_wb_data, 64'h1111);
        check_val("b2b_ready_again", {63'd0, o_ready}, 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        check_val("b2b_gap", {63'd0, o_wb_valid}, 64'd0);
        @(posedge clk); #1;
        check_val("b2b_second_valid", {63'd0, o_wb_valid}, 64'd1);
        check_val("b2b_second_data", o_wb_data, 64'h2222);
        @(posedge clk); #1;

        // Reset while REQ is stalled: request must drop without a clock edge.
        i_valid = 1'b1; i_ls_info = LW; i_mem_addr = 32'h8000_0000;
        @(posedge clk); #1;
        i_valid = 1'b0; i_ls_info = NOP;
        check_val("rstreq_req_before", {63'd0, o_bus_req}, 64'd1);
        rst_n = 1'b0; #1;
        check_val("rstreq_req_async", {63'd0, o_bus_req}, 64'd0);
        check_val("rstreq_ready_async", {63'd0, o_ready}, 64'd1);
        #3 rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            i_bus_gnt = 1'b1; i_bus_rvalid = 1'b1;
            @(posedge clk); #1;
            if (o_wb_valid) pulses++;
        end
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
        check_val("rstreq_no_pulse", 64'(pulses), 64'd0);

        // Reset in WAIT: abandoned load never reaches write-back.
        i_valid = 1'b1; i_ls_info = LW; i_mem_addr = 32'h8000_0000; i_bus_gnt = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_ls_info = NOP;
        @(posedge clk); #1;
        i_bus_gnt = 1'b0;
        rst_n = 1'b0; #1;
        check_val("rstwait_req", {63'd0, o_bus_req}, 64'd0);
        #3 rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            i_bus_rvalid = 1'b1; i_bus_rdata = 64'h5555_5555_5555_5555;
            @(posedge clk); #1;
            if (o_wb_valid) pulses++;
        end
        i_bus_rvalid = 1'b0;
        check_val("rstwait_no_pulse", 64'(pulses), 64'd0);
        check_val("rstwait_ready", {63'd0, o_ready}, 64'd1);
        check_val("rstwait_wb_data", o_wb_data, 64'd0);

        // 32-bit build.
        run32("x32_ld",   LD,  32'h8000_0000, 32'd0,          1, 32'd0,          1, 2'd3);
        run32("x32_lwu",  LWU, 32'h8000_0000, 32'd0,          1, 32'd0,          1, 2'd3);
        run32("x32_lw",   LW,  32'h8000_0000, 32'h8765_4321,  3, 32'h8765_4321,  0, 2'd0);
        run32("x32_lb",   LB,  32'h8000_0003, 32'h80FF_FFFF,  3, 32'hFFFF_FF80,  0, 2'd0);
        run32("x32_lhu",  LHU, 32'h8000_0002, 32'hBEEF_1234,  3, 32'h0000_BEEF,  0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
